// File: rtl/gray_checker.sv
// Checks that a 3-bit Gray stream from an upstream counter only holds or steps by one,
// decoding it to binary and counting 7->0 wraps. Define GRAY_CHECKER_BIDIR_EN to also accept down-steps.
module gray_checker (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       En,
  input  logic [2:0] GrayIn,
  input  logic       Resync,
  output logic [2:0] Binary,
  output logic [7:0] Wraps,
  output logic       StepErr,
  output logic       Tracking
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t     state;
  state_t     nxtstate;
  logic [2:0] prev;
  logic [2:0] nxtprev;
  logic [2:0] nxtbinary;
  logic [7:0] nxtwraps;
  logic [2:0] decoded;
  logic       stepup;
  logic       stepdown;
  logic       wrapstep;

  assign decoded[2] = GrayIn[2];
  assign decoded[1] = GrayIn[2] ^ GrayIn[1];
  assign decoded[0] = decoded[1] ^ GrayIn[0];

  assign stepup   = (decoded == (prev + 3'd1));
  assign wrapstep = stepup && (prev == 3'd7);

`ifdef GRAY_CHECKER_BIDIR_EN
  assign stepdown = (decoded == (prev - 3'd1));
`else
  assign stepdown = 1'b0;
`endif

  // Resync outranks the sample: the same-cycle GrayIn is dropped, Wraps survives.
  always_comb begin
    nxtstate  = state;
    nxtprev   = prev;
    nxtwraps  = Wraps;
    nxtbinary = Binary;
    if (Resync) begin
      nxtstate = IDLE;
    end else if (En) begin
      nxtbinary = decoded;
      case (state)
        IDLE: begin
          nxtprev  = decoded;
          nxtstate = TRACK;
        end
        TRACK: begin
          if (decoded == prev) begin
            nxtprev = prev;
          end else if (stepup) begin
            nxtprev = decoded;
            if (wrapstep && (Wraps != 8'hFF)) begin
              nxtwraps = Wraps + 8'd1;
            end
          end else if (stepdown) begin
            nxtprev = decoded;
          end else begin
            nxtstate = FAULT;
          end
        end
        FAULT: begin
          nxtstate = FAULT;
        end
        default: begin
          nxtstate = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      prev   <= 3'd0;
      Binary <= 3'd0;
      Wraps  <= 8'd0;
    end else begin
      state  <= nxtstate;
      prev   <= nxtprev;
      Binary <= nxtbinary;
      Wraps  <= nxtwraps;
    end
  end

  assign StepErr  = (state == FAULT);
  assign Tracking = (state == TRACK);

endmodule

// File: tb/tb_gray_checker.sv
// Directed self-checking bench for gray_checker; expectations are hand-computed per step.
module tb_gray_checker;

  logic       Clk;
  logic       Reset;
  logic       En;
  logic [2:0] GrayIn;
  logic       Resync;
  logic [2:0] Binary;
  logic [7:0] Wraps;
  logic       StepErr;
  logic       Tracking;

  int nasserts = 0;
  int nfails   = 0;

  logic [2:0] gtab [0:7] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  gray_checker dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (En),
    .GrayIn   (GrayIn),
    .Resync   (Resync),
    .Binary   (Binary),
    .Wraps    (Wraps),
    .StepErr  (StepErr),
    .Tracking (Tracking)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task applyStimulus(input logic en, input logic [2:0] g, input logic rs, input logic rst);
    @(negedge Clk);
    En     = en;
    GrayIn = g;
    Resync = rs;
    Reset  = rst;
    @(posedge Clk);
    #1;
  endtask

  task checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nasserts++;
    assert (obs === exp) else begin
      nfails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task checkAll(input string tag, input logic [2:0] bin, input logic [7:0] wr,
                input logic err, input logic trk);
    checkOutput({tag, ".bin"}, {5'd0, Binary}, {5'd0, bin});
    checkOutput({tag, ".wraps"}, Wraps, wr);
    checkOutput({tag, ".err"}, {7'd0, StepErr}, {7'd0, err});
    checkOutput({tag, ".trk"}, {7'd0, Tracking}, {7'd0, trk});
  endtask

  initial begin
    Reset  = 1'b1;
    En     = 1'b0;
    GrayIn = 3'b000;
    Resync = 1'b0;

    applyStimulus(1'b0, 3'b000, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'b111, 1'b0, 1'b1);
    checkAll("reset", 3'd0, 8'd0, 1'b0, 1'b0);

    // Full upward cycle ending in one wrap
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, gtab[i], 1'b0, 1'b0);
      checkAll($sformatf("seq%0d", i), i[2:0], 8'd0, 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
    checkAll("seqwrap", 3'd0, 8'd1, 1'b0, 1'b1);

    // Skip from 1 to 3 faults; later codes update Binary but not Wraps or StepErr
    applyStimulus(1'b1, 3'b001, 1'b0, 1'b0);
    checkAll("skip.pre", 3'd1, 8'd1, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b0);
    checkAll("skip.fault", 3'd3, 8'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'b110, 1'b0, 1'b0);
    checkAll("fault.b4", 3'd4, 8'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'b111, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b101, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b100, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
    checkAll("fault.b0", 3'd0, 8'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b0);
    checkAll("fault.b3", 3'd3, 8'd1, 1'b1, 1'b0);

    // Resync drops its own sample, clears the fault, keeps Wraps
    applyStimulus(1'b1, 3'b000, 1'b1, 1'b0);
    checkAll("resync", 3'd3, 8'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
    checkAll("resync.cap", 3'd0, 8'd1, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'b001, 1'b0, 1'b0);
    checkAll("resync.step", 3'd1, 8'd1, 1'b0, 1'b1);

    // Mid-stream reset, then an arbitrary first sample is captured unchecked
    applyStimulus(1'b1, 3'b011, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b110, 1'b1, 1'b1);
    checkAll("midreset", 3'd0, 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b101, 1'b0, 1'b0);
    checkAll("midreset.cap", 3'd6, 8'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'b100, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
    checkAll("midreset.wrap", 3'd0, 8'd1, 1'b0, 1'b1);

    // Holds, then En low freezes everything
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3'b011, 1'b0, 1'b0);
      checkAll($sformatf("hold%0d", i), 3'd2, 8'd0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 3'b101, 1'b0, 1'b0);
      checkAll($sformatf("idle%0d", i), 3'd2, 8'd0, 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b0);
    checkAll("afteridle", 3'd3, 8'd0, 1'b0, 1'b1);

    // Downward steps
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'b011, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b001, 1'b0, 1'b0);
`ifdef GRAY_CHECKER_BIDIR_EN
    checkAll("down", 3'd1, 8'd0, 1'b0, 1'b1);
`else
    checkAll("down", 3'd1, 8'd0, 1'b1, 1'b0);
`endif
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b100, 1'b0, 1'b0);
`ifdef GRAY_CHECKER_BIDIR_EN
    checkAll("downwrap", 3'd7, 8'd0, 1'b0, 1'b1);
`else
    checkAll("downwrap", 3'd7, 8'd0, 1'b1, 1'b0);
`endif

    // Saturation: the first pass only captures, each later pass wraps once
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b1);
    for (int c = 0; c < 260; c++) begin
      for (int i = 0; i < 8; i++) begin
        applyStimulus(1'b1, gtab[i], 1'b0, 1'b0);
        if (c == 200 && i == 0) checkOutput("wraps200", Wraps, 8'd200);
      end
    end
    checkAll("sat", 3'd7, 8'd255, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
    checkAll("sat.more", 3'd0, 8'd255, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfails);
    $finish;
  end

endmodule
